// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, instruction-memory address and the
// IF/ID pipeline register. Supports hazard stalls, EX redirects, a start
// handshake after reset, and a halt word that freezes fetch until reset.
module fetch_stage #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect,
  input  logic [7:0]  redirect_addr,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_instr,
  output logic [7:0]  if_pc,
  output logic [7:0]  if_pc_next,
  output logic        if_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [7:0]  if_pc_q, if_pc_d;
  logic [7:0]  if_pc_next_q, if_pc_next_d;
  logic        if_valid_q, if_valid_d;
  logic        halted_q, halted_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  // Next-state and IF/ID update; every register holds unless a rule below fires.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc_next_d  = if_pc_next_q;
    if_valid_d    = if_valid_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      ST_IDLE: begin
        // No fetch while idle, but a redirect may still preset the PC.
        if_valid_d = 1'b0;
        if (redirect) begin
          pc_d = redirect_addr;
        end else begin
          pc_d = pc_q;
        end
        if (start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (redirect) begin
          // Taken branch/jump squashes the word in flight: insert one bubble.
          pc_d         = redirect_addr;
          if_instr_d   = 32'h0000_0000;
          if_valid_d   = 1'b0;
          if_pc_d      = 8'h00;
          if_pc_next_d = 8'h00;
        end else if (stall) begin
          // Hazard hold: all registers keep their defaults.
          pc_d = pc_q;
        end else if (imem_rdata == HALT_WORD) begin
          // Halt word is never issued; PC stays pointing at it.
          state_d    = ST_HALTED;
          if_instr_d = 32'h0000_0000;
          if_valid_d = 1'b0;
          halted_d   = 1'b1;
        end else begin
          if_instr_d    = imem_rdata;
          if_pc_d       = pc_q;
          if_pc_next_d  = pc_q + 8'd1;
          if_valid_d    = 1'b1;
          pc_d          = pc_q + 8'd1;
          fetch_count_d = fetch_count_q + 16'd1;
        end
      end

      ST_HALTED: begin
        // Frozen until reset; start, stall and redirect are ignored.
        if_valid_d = 1'b0;
        halted_d   = 1'b1;
      end

      default: begin
        state_d    = ST_IDLE;
        if_valid_d = 1'b0;
        halted_d   = 1'b0;
      end
    endcase
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      if_instr_q    <= 32'h0000_0000;
      if_pc_q       <= 8'h00;
      if_pc_next_q  <= 8'h00;
      if_valid_q    <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_next_q  <= if_pc_next_d;
      if_valid_q    <= if_valid_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_pc_next  = if_pc_next_q;
  assign if_valid    = if_valid_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stimulus, all compared every cycle against a behavioural reference model.
module tb_fetch_stage;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_addr = 8'h00;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_instr;
  logic [7:0]  if_pc;
  logic [7:0]  if_pc_next;
  logic        if_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] mem [256];
  assign imem_rdata = mem[imem_addr];

  fetch_stage #(.RESET_PC(8'h00), .HALT_WORD(HALT)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_next(if_pc_next),
    .if_valid(if_valid), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: "running" and "stopped" flags instead of a state code.
  bit          m_running, m_stopped;
  logic [7:0]  m_pc;
  logic [31:0] m_instr;
  logic [7:0]  m_ipc, m_ipcn;
  bit          m_valid;
  int          m_count;   // kept unbounded; compared modulo 2^16

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("imem_addr",   {24'h0, imem_addr},   {24'h0, m_pc});
    chk("if_instr",    if_instr,             m_instr);
    chk("if_pc",       {24'h0, if_pc},       {24'h0, m_ipc});
    chk("if_pc_next",  {24'h0, if_pc_next},  {24'h0, m_ipcn});
    chk("if_valid",    {31'h0, if_valid},    {31'h0, m_valid});
    chk("halted",      {31'h0, halted},      {31'h0, m_stopped});
    chk("fetch_count", {16'h0, fetch_count}, m_count % 65536);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'($urandom_range(1));
    stall = 1'($urandom_range(1));
    redirect = 1'($urandom_range(1));
    redirect_addr = 8'($urandom);
    @(posedge clk);
    m_running = 0; m_stopped = 0; m_pc = 8'h00; m_instr = 32'h0;
    m_ipc = 8'h00; m_ipcn = 8'h00; m_valid = 0; m_count = 0;
    #1;
    rst = 1'b0;
    check_all();
  endtask

  // One clock with the given inputs; model advances from the word at its PC.
  task automatic cycle(input bit st, input bit sl, input bit rd, input logic [7:0] ra);
    logic [31:0] w;
    start = st; stall = sl; redirect = rd; redirect_addr = ra;
    w = mem[m_pc];
    @(posedge clk);
    if (m_stopped) begin
      // nothing moves
    end else if (!m_running) begin
      if (rd) m_pc = ra;
      if (st) m_running = 1;
      m_valid = 0;
    end else if (rd) begin
      m_pc = ra; m_instr = 32'h0; m_valid = 0; m_ipc = 8'h00; m_ipcn = 8'h00;
    end else if (sl) begin
      // hold
    end else if (w == HALT) begin
      m_running = 0; m_stopped = 1; m_instr = 32'h0; m_valid = 0;
    end else begin
      m_instr = w; m_ipc = m_pc; m_ipcn = 8'((m_pc + 1) % 256);
      m_pc = 8'((m_pc + 1) % 256); m_valid = 1; m_count = m_count + 1;
    end
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'h2001_0003;
    mem[1] = 32'h2002_0009;
    mem[2] = 32'h0022_1020;

    // Reset state
    do_reset();
    chk("reset_valid", {31'h0, if_valid}, 32'd0);

    // Start and straight-line fetch
    cycle(1, 0, 0, 8'h00);
    chk("start_no_capture", {31'h0, if_valid}, 32'd0);
    cycle(0, 0, 0, 8'h00);
    chk("first_word", if_instr, 32'h2001_0003);
    cycle(0, 0, 0, 8'h00);
    chk("second_word", if_instr, 32'h2002_0009);

    // Stall two cycles with pc=2
    cycle(0, 1, 0, 8'h00);
    cycle(0, 1, 0, 8'h00);
    chk("stall_hold_instr", if_instr, 32'h2002_0009);
    chk("stall_hold_pc", {24'h0, imem_addr}, 32'h2);
    cycle(0, 0, 0, 8'h00);
    chk("resume_word", if_instr, 32'h0022_1020);
    chk("count_three", {16'h0, fetch_count}, 32'd3);
    chk("pc_next_three", {24'h0, if_pc_next}, 32'h3);

    // Redirect together with stall: redirect wins, one bubble
    cycle(0, 1, 1, 8'h05);
    chk("bubble_valid", {31'h0, if_valid}, 32'd0);
    cycle(0, 0, 0, 8'h00);
    chk("redir_pc", {24'h0, if_pc}, 32'h5);
    chk("redir_word", if_instr, 32'h1000_0005);

    // PC wrap at 0xFF
    cycle(0, 0, 1, 8'hFE);
    cycle(0, 0, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);
    chk("wrap_pc", {24'h0, if_pc}, 32'hFF);
    chk("wrap_next", {24'h0, if_pc_next}, 32'h0);
    chk("wrap_addr", {24'h0, imem_addr}, 32'h0);
    cycle(0, 0, 0, 8'h00);

    // Halt word at address 3
    mem[3] = HALT;
    do_reset();
    cycle(1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);
    chk("halt_flag", {31'h0, halted}, 32'd1);
    chk("halt_pc", {24'h0, imem_addr}, 32'h3);
    chk("halt_count", {16'h0, fetch_count}, 32'd3);
    cycle(1, 0, 1, 8'h09);
    cycle(1, 1, 0, 8'h00);
    chk("halt_ignores", {24'h0, imem_addr}, 32'h3);
    do_reset();
    chk("reset_after_halt", {31'h0, halted}, 32'd0);

    // Redirect in the cycle the halt word is presented
    cycle(1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 8'h00);
    cycle(0, 0, 1, 8'h10);
    chk("redir_beats_halt", {31'h0, halted}, 32'd0);
    cycle(0, 0, 0, 8'h00);
    chk("redir_after_halt_word", if_instr, 32'h1000_0010);

    // Random phase: random memory with sprinkled halt words
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(15) == 0) ? HALT : $urandom;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(39) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(7) == 0)
          mem[$urandom_range(255)] = ($urandom_range(15) == 0) ? HALT : $urandom;
        cycle(($urandom_range(7) == 0), ($urandom_range(3) == 0),
              ($urandom_range(7) == 0), 8'($urandom));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the single-issue MIPS core. Holds the program counter, drives the word address of the combinational instruction memory and captures the returned word into the IF/ID pipeline register consumed by the decoder. Supports hazard stalls, taken branch/jump redirects from EX, a start handshake after reset and a halt word that freezes fetch.

## Interface

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction word that stops fetch.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  single-cycle pulse; leaves IDLE and begins fetching.
- stall  input  1  hazard unit hold; PC and IF/ID register keep their values.
- redirect  input  1  taken branch/jump from EX.
- redirect_addr  input  8  new word address when redirect=1.
- imem_addr  output  8  word address to instruction memory; equals PC register.
- imem_rdata  input  32  instruction word from memory, combinational on imem_addr.
- if_instr  output  32  IF/ID instruction.
- if_pc  output  8  IF/ID address of if_instr.
- if_pc_next  output  8  IF/ID if_pc + 1, mod 256.
- if_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  high in HALTED state.
- fetch_count  output  16  number of instructions captured into IF/ID.

## Operation

- States: IDLE, RUN, HALTED. Reset state IDLE.
- IDLE: no fetch; if_valid=0. start=1 -> RUN next cycle. redirect in IDLE loads PC, stays IDLE.
- RUN, per cycle, priority highest first:
  - redirect=1: pc <= redirect_addr; if_instr <= 0, if_valid <= 0 (bubble); if_pc, if_pc_next <= 0; fetch_count unchanged. Wins over stall and halt detection.
  - stall=1: pc, if_instr, if_pc, if_pc_next, if_valid, fetch_count hold.
  - imem_rdata == HALT_WORD: -> HALTED; pc holds; if_valid <= 0, if_instr <= 0; halt word is never issued; count unchanged.
  - otherwise: if_instr <= imem_rdata, if_pc <= pc, if_pc_next <= pc+1, if_valid <= 1, pc <= pc+1, fetch_count <= fetch_count+1.
- HALTED: pc and IF/ID frozen with if_valid=0; start, stall, redirect ignored; exit only by rst.
- Arithmetic: pc+1 is 8-bit, wraps 8'hFF -> 8'h00. fetch_count is 16-bit, wraps 16'hFFFF -> 0.
- start while already in RUN or HALTED has no effect.

## Timing

- Reset (rst=1 at edge): pc=RESET_PC, if_instr=0, if_pc=0, if_pc_next=0, if_valid=0, halted=0, fetch_count=0, state IDLE. rst overrides all other inputs, including mid-stall or mid-redirect.
- imem_addr is the PC register output, no combinational path from any input.
- start at edge N -> state RUN after N; first capture at edge N+1; if_valid=1 after edge N+1 with if_instr = word at RESET_PC.
- Fetch latency: word at address X appears on if_instr one cycle after pc==X. Throughput one instruction per cycle without stall.
- Redirect at edge N: one bubble on IF/ID after N; word at redirect_addr on if_instr after edge N+1.
- halted asserts the cycle after the edge where HALT_WORD is seen.

## Test plan

- Reset then start, memory loaded with 0x20010003, 0x20020009, 0x00221020 at 0..2 -> if_instr sequence 0x20010003, 0x20020009, 0x00221020 on consecutive cycles, if_pc 0,1,2, if_pc_next 1,2,3, fetch_count 3.
- stall high 2 cycles while pc=2 -> if_instr stays 0x20020009, pc stays 2, fetch_count frozen; after release resumes at 0x00221020 with no skip or duplicate.
- redirect=1, redirect_addr=8'h05 with stall=1 simultaneously -> next cycle if_valid=0, if_instr=0; following cycle if_pc=5, word at address 5 captured.
- PC run to 8'hFF with non-halt words -> captures address 0xFF, if_pc_next=0x00, next pc=0x00.
- HALT_WORD at address 3 -> after capturing addr 2, halted=1, if_valid=0, pc=3, fetch_count=3; subsequent start/redirect ignored; rst returns to IDLE with all outputs at reset values.
- Redirect in the same cycle HALT_WORD is on imem_rdata -> no halt; fetch continues at redirect_addr.
